// File: rtl/cam_subarray.sv
// 36-row x 16-entry, 2-bit-per-cell CAM subarray: masked row writes and
// single/dual-row parallel searches producing a registered 16-bit match tag.
module cam_subarray (
    input  logic        CLK,
    input  logic        rst,
    input  logic        chip_enable,
    input  logic [2:0]  operation_mode,
    input  logic        addr_select,
    input  logic [15:0] data_in,
    input  logic        update_signal,
    input  logic [15:0] tag_in,
    input  logic [9:0]  cmp_addr,
    input  logic [3:0]  ppg_addr,
    input  logic [1:0]  cmp_data,
    input  logic [1:0]  ppg_data,
    output logic [15:0] tag_out,
    output logic        write_done
);

    localparam int unsigned ROWS    = 36;
    localparam int unsigned COLS    = 32;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned BITS    = ROWS * COLS;
    localparam int unsigned ROW_W   = 6;
    localparam int unsigned IDX_W   = 11;

    typedef enum logic [2:0] {
        OP_WRITE    = 3'b000,
        OP_UPDATE   = 3'b001,
        OP_SRCH_CMP = 3'b010,
        OP_SRCH_PPG = 3'b011,
        OP_DUAL_CMP = 3'b100,
        OP_DUAL_PPG = 3'b101,
        OP_CMP_PPG  = 3'b110,
        OP_NOP      = 3'b111
    } op_e;

    // Bit (row r, column c) lives at r*32+c, i.e. index {r, c}.
    logic mem [0:BITS-1];

    op_e                op_c;
    logic [ROW_W-1:0]   cmp_row_a_c;
    logic [ROW_W-1:0]   cmp_row_b_c;
    logic [ROW_W-1:0]   ppg_row_a_c;
    logic [ROW_W-1:0]   ppg_row_b_c;
    logic [ROW_W-1:0]   wr_row_c;
    logic [1:0]         wr_key_c;
    logic               wr_en_c;
    logic [COLS-1:0]    wr_mask_c;
    logic [COLS-1:0]    wr_bits_c;
    logic               srch_en_c;
    logic [ENTRIES-1:0] srch_tag_c;

    assign op_c        = op_e'(operation_mode);
    assign cmp_row_a_c = {1'b0, cmp_addr[4:0]};
    assign cmp_row_b_c = {1'b0, cmp_addr[9:5]};
    assign ppg_row_a_c = {4'b1000, ppg_addr[1:0]};
    assign ppg_row_b_c = {4'b1000, ppg_addr[3:2]};
    assign wr_row_c    = addr_select ? ppg_row_a_c : cmp_row_a_c;
    assign wr_key_c    = addr_select ? ppg_data : cmp_data;

    // Per-entry equality of one stored row against a 2-bit key.
    function automatic logic [ENTRIES-1:0] match_row(input logic [ROW_W-1:0] row,
                                                     input logic [1:0]       key);
        logic [ENTRIES-1:0] hit;
        hit = '0;
        for (int k = 0; k < int'(ENTRIES); k++) begin
            hit[4'(k)] = ({mem[IDX_W'({row, 4'(k), 1'b1})],
                           mem[IDX_W'({row, 4'(k), 1'b0})]} == key);
        end
        return hit;
    endfunction

    // Operation decode: write enables/data and search result for this cycle.
    always_comb begin
        wr_en_c    = 1'b0;
        wr_mask_c  = '0;
        wr_bits_c  = '0;
        srch_en_c  = 1'b0;
        srch_tag_c = '0;
        if (chip_enable) begin
            case (op_c)
                OP_WRITE: begin
                    wr_en_c   = 1'b1;
                    wr_mask_c = '1;
                    for (int k = 0; k < int'(ENTRIES); k++) begin
                        wr_bits_c[{4'(k), 1'b1}] = data_in[4'(k)];
                        wr_bits_c[{4'(k), 1'b0}] = data_in[4'(k)];
                    end
                end
                OP_UPDATE: begin
                    if (update_signal) begin
                        wr_en_c = 1'b1;
                        for (int k = 0; k < int'(ENTRIES); k++) begin
                            wr_mask_c[{4'(k), 1'b1}] = tag_in[4'(k)];
                            wr_mask_c[{4'(k), 1'b0}] = tag_in[4'(k)];
                            wr_bits_c[{4'(k), 1'b1}] = wr_key_c[1];
                            wr_bits_c[{4'(k), 1'b0}] = wr_key_c[0];
                        end
                    end
                end
                OP_SRCH_CMP: begin
                    srch_en_c  = 1'b1;
                    srch_tag_c = match_row(cmp_row_a_c, cmp_data);
                end
                OP_SRCH_PPG: begin
                    srch_en_c  = 1'b1;
                    srch_tag_c = match_row(ppg_row_a_c, ppg_data);
                end
                OP_DUAL_CMP: begin
                    srch_en_c  = 1'b1;
                    srch_tag_c = match_row(cmp_row_a_c, cmp_data)
                               & match_row(cmp_row_b_c, cmp_data);
                end
                OP_DUAL_PPG: begin
                    srch_en_c  = 1'b1;
                    srch_tag_c = match_row(ppg_row_a_c, ppg_data)
                               & match_row(ppg_row_b_c, ppg_data);
                end
                OP_CMP_PPG: begin
                    srch_en_c  = 1'b1;
                    srch_tag_c = match_row(cmp_row_a_c, cmp_data)
                               & match_row(ppg_row_a_c, ppg_data);
                end
                default: ;
            endcase
        end
    end

    // Storage and registered outputs; reset wipes the whole array.
    always_ff @(posedge CLK) begin
        if (rst) begin
            tag_out    <= '0;
            write_done <= 1'b0;
            for (int i = 0; i < int'(BITS); i++) begin
                mem[IDX_W'(i)] <= 1'b0;
            end
        end else begin
            write_done <= wr_en_c;
            if (srch_en_c) begin
                tag_out <= srch_tag_c;
            end
            if (wr_en_c) begin
                for (int c = 0; c < int'(COLS); c++) begin
                    if (wr_mask_c[5'(c)]) begin
                        mem[IDX_W'({wr_row_c, 5'(c)})] <= wr_bits_c[5'(c)];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_subarray.sv
// Scoreboard bench for cam_subarray: a reference model predicts tag_out and
// write_done per operation; memory contents are compared row by row.
module tb_cam_subarray;

    logic        CLK = 1'b0;
    logic        rst;
    logic        chip_enable;
    logic [2:0]  operation_mode;
    logic        addr_select;
    logic [15:0] data_in;
    logic        update_signal;
    logic [15:0] tag_in;
    logic [9:0]  cmp_addr;
    logic [3:0]  ppg_addr;
    logic [1:0]  cmp_data;
    logic [1:0]  ppg_data;
    logic [15:0] tag_out;
    logic        write_done;

    cam_subarray dut (
        .CLK            (CLK),
        .rst            (rst),
        .chip_enable    (chip_enable),
        .operation_mode (operation_mode),
        .addr_select    (addr_select),
        .data_in        (data_in),
        .update_signal  (update_signal),
        .tag_in         (tag_in),
        .cmp_addr       (cmp_addr),
        .ppg_addr       (ppg_addr),
        .cmp_data       (cmp_data),
        .ppg_data       (ppg_data),
        .tag_out        (tag_out),
        .write_done     (write_done)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] tag;
        logic        wd;
    } exp_t;

    exp_t        sb[$];
    logic [1:0]  model [0:35][0:15];
    logic [15:0] model_tag;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model_match(input int row, input logic [1:0] key);
        logic [15:0] m;
        for (int k = 0; k < 16; k++) m[k] = (model[row][k] == key);
        return m;
    endfunction

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check_eq({e.name, "_tag"}, {16'h0, tag_out}, {16'h0, e.tag});
            check_eq({e.name, "_wd"}, {31'h0, write_done}, {31'h0, e.wd});
        end
    endtask

    task automatic check_mem(input string name);
        logic [31:0] got, exp;
        for (int r = 0; r < 36; r++) begin
            for (int k = 0; k < 16; k++) begin
                got[2*k+1] = dut.mem[r*32+2*k+1];
                got[2*k]   = dut.mem[r*32+2*k];
                exp[2*k+:2] = model[r][k];
            end
            check_eq($sformatf("%s_row%0d", name, r), got, exp);
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        for (int r = 0; r < 36; r++)
            for (int k = 0; k < 16; k++) model[r][k] = 2'b00;
        model_tag = 16'h0;
        sb.push_back('{name, 16'h0, 1'b0});
        @(posedge CLK); #1;
        compare_out();
        rst = 1'b0;
    endtask

    task automatic do_op(input logic ce, input logic [2:0] mode, input logic asel,
                         input logic [15:0] din, input logic upd, input logic [15:0] tin,
                         input logic [9:0] ca, input logic [3:0] pa,
                         input logic [1:0] cd, input logic [1:0] pd, input string name);
        int   wrow;
        logic [1:0] key;
        logic wd;
        chip_enable = ce; operation_mode = mode; addr_select = asel; data_in = din;
        update_signal = upd; tag_in = tin; cmp_addr = ca; ppg_addr = pa;
        cmp_data = cd; ppg_data = pd;
        wrow = asel ? 32 + int'(pa[1:0]) : int'(ca[4:0]);
        key  = asel ? pd : cd;
        wd   = 1'b0;
        if (ce) begin
            case (mode)
                3'd0: begin
                    for (int k = 0; k < 16; k++) model[wrow][k] = {din[k], din[k]};
                    wd = 1'b1;
                end
                3'd1: if (upd) begin
                    for (int k = 0; k < 16; k++) if (tin[k]) model[wrow][k] = key;
                    wd = 1'b1;
                end
                3'd2: model_tag = model_match(int'(ca[4:0]), cd);
                3'd3: model_tag = model_match(32 + int'(pa[1:0]), pd);
                3'd4: model_tag = model_match(int'(ca[4:0]), cd) & model_match(int'(ca[9:5]), cd);
                3'd5: model_tag = model_match(32 + int'(pa[1:0]), pd)
                                & model_match(32 + int'(pa[3:2]), pd);
                3'd6: model_tag = model_match(int'(ca[4:0]), cd)
                                & model_match(32 + int'(pa[1:0]), pd);
                default: ;
            endcase
        end
        sb.push_back('{name, model_tag, wd});
        @(posedge CLK); #1;
        compare_out();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; chip_enable = 1'b0; operation_mode = 3'd7; addr_select = 1'b0;
        data_in = '0; update_signal = 1'b0; tag_in = '0; cmp_addr = '0; ppg_addr = '0;
        cmp_data = '0; ppg_data = '0;
        @(negedge CLK);

        do_reset("reset");
        check_mem("reset_mem");

        do_op(1, 3'd0, 1, 16'hFFFF, 0, 16'h0, 10'h0, 4'b0100, 2'b00, 2'b00, "dwr_ppg");
        check_mem("dwr_mem");
        do_op(1, 3'd3, 1, 16'h0, 0, 16'h0, 10'h0, 4'b0100, 2'b00, 2'b11, "srch_ppg");
        do_op(1, 3'd5, 1, 16'h0, 0, 16'h0, 10'h0, 4'b0100, 2'b00, 2'b11, "dual_ppg");

        do_op(1, 3'd1, 0, 16'h0, 1, 16'hAAAA, 10'b00001_00000, 4'b0, 2'b01, 2'b00, "upd");
        do_op(1, 3'd1, 0, 16'h0, 0, 16'h5555, 10'b00001_00000, 4'b0, 2'b11, 2'b00, "upd_off");
        check_mem("upd_mem");

        do_op(1, 3'd2, 0, 16'h0, 0, 16'h0, 10'b00001_00000, 4'b0, 2'b01, 2'b00, "srch_cmp");
        do_op(1, 3'd4, 0, 16'h0, 0, 16'h0, 10'b00001_00000, 4'b0, 2'b01, 2'b00, "dual_cmp");
        do_op(1, 3'd6, 0, 16'h0, 0, 16'h0, 10'b00001_00000, 4'b0000, 2'b01, 2'b11, "cmp_ppg");
        do_op(1, 3'd4, 0, 16'h0, 0, 16'h0, 10'b00000_00000, 4'b0, 2'b01, 2'b00, "dual_same");

        do_op(0, 3'd0, 0, 16'hFFFF, 0, 16'h0, 10'd5, 4'b0, 2'b00, 2'b00, "ce_off");
        check_mem("ce_off_mem");
        do_op(1, 3'd7, 0, 16'hFFFF, 1, 16'hFFFF, 10'd5, 4'b0, 2'b00, 2'b00, "nop");

        for (int i = 0; i < 3; i++)
            do_op(1, 3'd0, 0, 16'h1234, 0, 16'h0, 10'd7, 4'b0, 2'b00, 2'b00, "wr_hold");
        do_op(1, 3'd2, 0, 16'h0, 0, 16'h0, 10'd7, 4'b0, 2'b11, 2'b00, "wr_then_srch");
        check_mem("hold_mem");

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset("rnd_reset");
            end else begin
                do_op(1'($urandom_range(0, 9) != 0), 3'($urandom_range(0, 7)),
                      1'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0),
                      16'($urandom), 10'($urandom), 4'($urandom),
                      2'($urandom), 2'($urandom), "rnd");
            end
        end
        check_mem("rnd_mem");

        do_op(1, 3'd0, 0, 16'hFFFF, 0, 16'h0, 10'd3, 4'b0, 2'b00, 2'b00, "pre_rst_wr");
        do_reset("mid_reset");
        check_mem("mid_reset_mem");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
